dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single byte-wide data memory between two word requesters: the processor load/store path (cpu) and the debug/loader port (dbg).
- Each 32-bit word access runs as four sequential byte cycles in big-endian order: byte at addr+0 is bits 31:24.
- Sits between the requesters and the 32-entry byte data memory, replacing direct 4-byte-wide access with a sequenced, arbitrated port.

Parameters:
- ADDR_W, 5, byte-address width; memory depth is 2**ADDR_W, and address arithmetic wraps modulo that depth.
- WORD_BYTES, 4, bytes per transfer; fixed at 4 with a 32-bit data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  cpu request; held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word base byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data.
- cpu_done  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_done: same as the cpu_* ports, for the debug port.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  byte write data.
- mem_rdata  in  8  byte read data, combinational from mem_addr.
- busy  out  1  state != IDLE.
- owner  out  1  0 = cpu, 1 = dbg; valid while busy.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, byte counter cnt=0, last_owner=dbg, so cpu wins the first tie.
  - All outputs are 0, including both rdata registers and the read buffer.
- States:
  - IDLE: sample requests at each posedge.
    - Only one req high: grant it.
    - Both high: grant the port != last_owner.
    - On a grant: latch we/addr/wdata of the winner, set owner and last_owner, cnt=0, go to XFER.
  - XFER: four cycles, cnt = 0..3.
    - mem_addr = (latched_addr + cnt) mod 2**ADDR_W. Wrap is required: base 30 accesses 30, 31, 0, 1.
    - Write: mem_we=1; mem_wdata = wdata[31-8*cnt -: 8].
    - Read: mem_we=0; at the posedge ending cycle cnt, buf[31-8*cnt -: 8] <= mem_rdata.
    - When cnt=3, go to DONE; the owner's rdata register loads the final buffer value, including the last byte.
  - DONE: one cycle.
    - Owner's done=1, then go to IDLE.
    - The non-owner's rdata is never modified.
    - rdata holds its value until that port's next read completes. Writes leave rdata unchanged.
- Outside XFER: mem_we=0, mem_addr=0, mem_wdata=0.
- Latency: req high in IDLE cycle 0 -> XFER cycles 1-4 -> done in cycle 5. Back-to-back grants are possible from cycle 6.
- Requester rule: drop req in the cycle after done is observed. A req still high in IDLE is a new request.
- req dropped mid-transfer: the transfer is committed. All 4 bytes complete and done still pulses.
- A new req from the other port during a transfer waits. It is granted in the IDLE cycle that follows DONE.
- Fairness: under continuous requests from both ports, grants strictly alternate. A lone requester is granted every time regardless of last_owner.
- Reset mid-transfer:
  - Transfer aborts immediately; bytes already written stay in memory and no done is issued.
  - last_owner returns to dbg.
- Simultaneous reset release and req: the first grant is evaluated at the first posedge with rst_n=1.

Test Plan:
- cpu write 0xDEADBEEF @4 -> mem_we high in cycles 1-4 with addr 4, 5, 6, 7 and data DE, AD, BE, EF; cpu_done in cycle 5 only; busy high in cycles 1-5.
- memory bytes 8-11 = 01 23 45 67; cpu read @8 -> cpu_rdata=0x01234567 at cycle 5; dbg_rdata stays 0.
- dbg write 0xA1B2C3D4 @30 -> bytes written in order 30, 31, 0, 1; then cpu read @30 returns 0xA1B2C3D4.
- cpu_req and dbg_req both high from reset release -> cpu served first (done cycle 5), dbg next (done cycle 11); with both held continuously, owner alternates cpu, dbg, cpu, dbg.
- dbg write 0x11223344 @16, rst_n low during the cnt=2 cycle -> bytes 16 and 17 updated, bytes 18 and 19 unchanged, no dbg_done, all outputs 0; with both requesting after release, cpu is granted.
- cpu_req dropped during XFER cnt=1 -> all 4 bytes still written and cpu_done pulses at cycle 5.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two word requesters, the arbiter and the byte-wide data memory.
// Handshake: a requester raises req with we/addr/wdata stable and holds it until it sees a
// one-cycle done; it drops req in the following cycle, and a req still high in IDLE is a new request.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;
    logic              dbg_done;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_done, dbg_rdata, dbg_done,
        output mem_addr, mem_we, mem_wdata, busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_done, dbg_rdata, dbg_done,
        input  mem_addr, mem_we, mem_wdata, busy, owner
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates cpu and dbg word accesses onto a byte-wide data memory, sequencing each word
// as four big-endian byte cycles with alternating priority on ties.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int WORD_BYTES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_port_arbiter_if.slave bus,
    output logic [1:0]         fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q;
    logic              last_owner_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       cpu_rdata_q, dbg_rdata_q;
    logic              grant, grant_dbg;
    logic [1:0]        byte_sel;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_we_d;
    logic [7:0]        mem_wdata_d;
    logic              busy;

    // Byte lane counted from the top: cnt 0 maps to bits 31:24.
    assign byte_sel = LAST_BYTE - cnt_q;

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_dbg   = 1'b0;
        buf_d       = buf_q;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    grant     = 1'b1;
                    // On a tie the port that did not go last wins.
                    grant_dbg = bus.dbg_req && (!bus.cpu_req || !last_owner_q);
                    state_d   = XFER;
                end
            end
            XFER: begin
                mem_addr_d = addr_q + ADDR_W'(cnt_q);
                mem_we_d   = we_q;
                if (we_q) begin
                    mem_wdata_d = wdata_q[{byte_sel, 3'b000} +: 8];
                end else begin
                    buf_d[{byte_sel, 3'b000} +: 8] = bus.mem_rdata;
                end
                if (cnt_q == LAST_BYTE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q      <= grant_dbg;
                last_owner_q <= grant_dbg;
                we_q         <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
                addr_q       <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                wdata_q      <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                cnt_q        <= 2'd0;
            end
            if (state_q == XFER) begin
                cnt_q <= cnt_q + 2'd1;
                buf_q <= buf_d;
                // buf_d already holds the last byte, so the result is complete here.
                if (cnt_q == LAST_BYTE && !we_q) begin
                    if (owner_q) begin
                        dbg_rdata_q <= buf_d;
                    end else begin
                        cpu_rdata_q <= buf_d;
                    end
                end
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign bus.busy      = busy;
    assign bus.owner     = owner_q & busy;
    assign bus.cpu_done  = (state_q == DONE) && !owner_q;
    assign bus.dbg_done  = (state_q == DONE) && owner_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.mem_we    = mem_we_d;
    assign bus.mem_wdata = mem_wdata_d;
    assign fsm_state     = state_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random rounds, checked cycle by cycle
// against a word-level model of memory contents, grant order and completion timing.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef struct {
        bit              req;
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]     wdata;
        int              drop_at;
    } txn_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    logic [1:0] fsm_state;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // byte memory behind the arbiter
    logic [7:0] mem [DEPTH];
    logic       mem_clr = 1'b1;
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // reference model state
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_rdata [2];
    int          ref_last;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit req, input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] wdata, input int drop_at);
        txn_t t;
        t.req = req; t.we = we; t.addr = addr; t.wdata = wdata; t.drop_at = drop_at;
        return t;
    endfunction

    function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[(int'(a) + i) % DEPTH]};
        return w;
    endfunction

    // driver tasks
    task automatic set_port(input int p, input txn_t t);
        if (p == 0) begin
            bus.cpu_req = t.req; bus.cpu_we = t.we; bus.cpu_addr = t.addr; bus.cpu_wdata = t.wdata;
        end else begin
            bus.dbg_req = t.req; bus.dbg_we = t.we; bus.dbg_addr = t.addr; bus.dbg_wdata = t.wdata;
        end
    endtask

    task automatic set_req(input int p, input bit v);
        if (p == 0) bus.cpu_req = v;
        else        bus.dbg_req = v;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cpu_rdata"}, bus.cpu_rdata, 32'h0);
        chk({tag, " dbg_rdata"}, bus.dbg_rdata, 32'h0);
        chk({tag, " cpu_done"},  bus.cpu_done,  32'h0);
        chk({tag, " dbg_done"},  bus.dbg_done,  32'h0);
        chk({tag, " mem_addr"},  bus.mem_addr,  32'h0);
        chk({tag, " mem_we"},    bus.mem_we,    32'h0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, " busy"},      bus.busy,      32'h0);
        chk({tag, " owner"},     bus.owner,     32'h0);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], ref_mem[i]);
    endtask

    // One arbitration round; called just after a negedge in an IDLE cycle (cycle 0 of the round).
    task automatic run_round(input string name, input txn_t tc, input txn_t td);
        txn_t        t [2];
        int          order [$];
        int          n, end_cyc, p, s, bi;
        int          done_k [2];
        bit          ex_busy, ex_we, ex_cd, ex_dd;
        int          ex_own;
        logic [ADDR_W-1:0] ex_addr;
        logic [7:0]  ex_wd;
        logic [31:0] w;
        t[0] = tc;
        t[1] = td;
        if (tc.req && td.req) begin
            order.push_back(1 - ref_last);
            order.push_back(ref_last);
        end else if (tc.req) begin
            order.push_back(0);
        end else begin
            order.push_back(1);
        end
        n = order.size();
        foreach (order[j]) begin
            p = order[j];
            if (t[p].we) begin
                w = t[p].wdata;
                for (int i = 0; i < 4; i++) ref_mem[(int'(t[p].addr) + i) % DEPTH] = w[31 - 8*i -: 8];
            end else begin
                ref_rdata[p] = ref_word(t[p].addr);
            end
        end
        end_cyc = 6 * (n - 1) + 5;
        done_k[0] = -10;
        done_k[1] = -10;
        set_port(0, tc);
        set_port(1, td);
        for (int k = 1; k <= end_cyc + 1; k++) begin
            @(posedge clk);
            #1;
            ex_busy = 0; ex_we = 0; ex_cd = 0; ex_dd = 0; ex_own = 0; ex_addr = '0; ex_wd = 8'h00;
            for (int j = 0; j < n; j++) begin
                s = 6 * j;
                if (k > s && k <= s + 5) begin
                    p = order[j];
                    ex_busy = 1;
                    ex_own = p;
                    if (k <= s + 4) begin
                        bi = k - s - 1;
                        w = t[p].wdata;
                        ex_we = t[p].we;
                        ex_addr = ADDR_W'((int'(t[p].addr) + bi) % DEPTH);
                        ex_wd = t[p].we ? w[31 - 8*bi -: 8] : 8'h00;
                    end else if (p == 0) begin
                        ex_cd = 1;
                    end else begin
                        ex_dd = 1;
                    end
                end
            end
            chk($sformatf("%s c%0d busy", name, k), bus.busy, 32'(ex_busy));
            if (ex_busy) chk($sformatf("%s c%0d owner", name, k), bus.owner, 32'(ex_own));
            chk($sformatf("%s c%0d mem_we", name, k), bus.mem_we, 32'(ex_we));
            chk($sformatf("%s c%0d mem_addr", name, k), bus.mem_addr, 32'(ex_addr));
            chk($sformatf("%s c%0d mem_wdata", name, k), bus.mem_wdata, 32'(ex_wd));
            chk($sformatf("%s c%0d cpu_done", name, k), bus.cpu_done, 32'(ex_cd));
            chk($sformatf("%s c%0d dbg_done", name, k), bus.dbg_done, 32'(ex_dd));
            for (int q = 0; q < 2; q++) begin
                if (k == t[q].drop_at || done_k[q] == k - 1) set_req(q, 1'b0);
            end
            if (bus.cpu_done) done_k[0] = k;
            if (bus.dbg_done) done_k[1] = k;
        end
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        chk({name, " cpu_rdata"}, bus.cpu_rdata, ref_rdata[0]);
        chk({name, " dbg_rdata"}, bus.dbg_rdata, ref_rdata[1]);
        ref_last = order[n - 1];
    endtask

    txn_t none;
    txn_t rc, rd;
    int   pat;

    initial begin
        none = mk(1'b0, 1'b0, '0, 32'h0, 0);
        set_port(0, none);
        set_port(1, none);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        ref_last = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        mem_clr = 1'b0;

        // both requesting from reset release: cpu first (done c5), dbg next (done c11)
        @(negedge clk);
        rst_n = 1'b1;
        run_round("tie0", mk(1, 1, 5'd4, 32'hDEADBEEF, 0), mk(1, 1, 5'd8, 32'h01234567, 0));
        @(negedge clk);
        run_round("cpu_rd8", mk(1, 0, 5'd8, 32'h0, 0), none);
        @(negedge clk);
        run_round("tie1", mk(1, 0, 5'd4, 32'h0, 0), mk(1, 0, 5'd8, 32'h0, 0));
        @(negedge clk);
        run_round("tie2", mk(1, 1, 5'd20, 32'hCAFEF00D, 0), mk(1, 0, 5'd4, 32'h0, 0));
        @(negedge clk);
        run_round("dbg_wr30", none, mk(1, 1, 5'd30, 32'hA1B2C3D4, 0));
        @(negedge clk);
        run_round("cpu_rd30", mk(1, 0, 5'd30, 32'h0, 0), none);
        @(negedge clk);
        run_round("cpu_drop", mk(1, 1, 5'd12, 32'h5A6B7C8D, 2), none);
        check_mem("directed");

        // reset during the cnt=2 cycle of a dbg write
        @(negedge clk);
        set_port(1, mk(1, 1, 5'd16, 32'h11223344, 0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_port(1, none);
        ref_mem[16] = 8'h11;
        ref_mem[17] = 8'h22;
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        ref_last = 1;
        #1;
        check_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst dbg_done", bus.dbg_done, 32'h0);
        end
        check_mem("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_round("post_rst", mk(1, 0, 5'd16, 32'h0, 0), mk(1, 0, 5'd18, 32'h0, 0));

        // random rounds
        for (int r = 0; r < 40; r++) begin
            pat = $urandom_range(1, 3);
            rc = mk(pat[0], 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, 0);
            rd = mk(pat[1], 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, 0);
            if (pat != 3 && $urandom_range(0, 3) == 0) begin
                rc.drop_at = $urandom_range(1, 4);
                rd.drop_at = rc.drop_at;
            end
            @(negedge clk);
            run_round($sformatf("rnd%0d", r), rc, rd);
        end
        check_mem("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
